// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, NZCV status register, branch target and EXE/MEM register
// Flags are written only for S instructions; a frozen pipeline holds both registers.

module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        mem_to_reg_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic        alu_src_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [31:0] sign_ext_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [4:0]  dest_in,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  status,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        mem_to_reg,
  output logic [31:0] alu_res,
  output logic [31:0] st_val,
  output logic [4:0]  dest
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [3:0]  status_q, status_d;
  logic        wb_en_q, mem_r_en_q, mem_w_en_q, mem_to_reg_q;
  logic [31:0] alu_res_q, st_val_q;
  logic [4:0]  dest_q;

  logic [31:0] op2;
  logic [31:0] addend;
  logic        cin;
  logic        is_arith;
  logic [32:0] sum;
  logic [31:0] res;
  logic        c_flag, v_flag;

  assign op2 = alu_src_in ? sign_ext_in : val_rm_in;

  // Subtraction is done as rn + ~op2 + cin so carry means "no borrow".
  always_comb begin
    addend   = op2;
    cin      = 1'b0;
    is_arith = 1'b0;
    case (exe_cmd_in)
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin is_arith = 1'b1; cin = status_q[1]; end
      CMD_SUB: begin is_arith = 1'b1; addend = ~op2; cin = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; addend = ~op2; cin = status_q[1]; end
      default: ;
    endcase
  end

  assign sum = {1'b0, val_rn_in} + {1'b0, addend} + {32'd0, cin};

  always_comb begin
    res = 32'd0;
    case (exe_cmd_in)
      CMD_MOV:                           res = op2;
      CMD_MVN:                           res = ~op2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: res = sum[31:0];
      CMD_AND:                           res = val_rn_in & op2;
      CMD_ORR:                           res = val_rn_in | op2;
      CMD_EOR:                           res = val_rn_in ^ op2;
      default:                           res = 32'd0;
    endcase
  end

  always_comb begin
    c_flag = status_q[1];
    v_flag = status_q[0];
    if (is_arith) begin
      c_flag = sum[32];
      v_flag = (val_rn_in[31] == addend[31]) && (res[31] != val_rn_in[31]);
    end
  end

  always_comb begin
    status_d = status_q;
    if (s_in && !freeze) status_d = {res[31], (res == 32'd0), c_flag, v_flag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q     <= 4'd0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_res_q    <= 32'd0;
      st_val_q     <= 32'd0;
      dest_q       <= 5'd0;
    end else begin
      status_q <= status_d;
      if (!freeze) begin
        wb_en_q      <= wb_en_in;
        mem_r_en_q   <= mem_r_en_in;
        mem_w_en_q   <= mem_w_en_in;
        mem_to_reg_q <= mem_to_reg_in;
        alu_res_q    <= res;
        st_val_q     <= val_rm_in;
        dest_q       <= dest_in;
      end
    end
  end

  // Redirect is combinational so fetch can change course in the same cycle.
  assign branch_taken = b_in;
  assign branch_addr  = next_pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  assign status     = status_q;
  assign wb_en      = wb_en_q;
  assign mem_r_en   = mem_r_en_q;
  assign mem_w_en   = mem_w_en_q;
  assign mem_to_reg = mem_to_reg_q;
  assign alu_res    = alu_res_q;
  assign st_val     = st_val_q;
  assign dest       = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage

module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, mem_to_reg_in;
  logic        b_in, s_in, alu_src_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] next_pc_in, val_rn_in, val_rm_in, sign_ext_in;
  logic [23:0] signed_imm_24_in;
  logic [4:0]  dest_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic        wb_en, mem_r_en, mem_w_en, mem_to_reg;
  logic [31:0] alu_res, st_val;
  logic [4:0]  dest;

  int total = 0;
  int bad   = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .mem_to_reg_in(mem_to_reg_in), .b_in(b_in), .s_in(s_in), .alu_src_in(alu_src_in),
    .exe_cmd_in(exe_cmd_in), .next_pc_in(next_pc_in), .val_rn_in(val_rn_in),
    .val_rm_in(val_rm_in), .sign_ext_in(sign_ext_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .status(status), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_to_reg(mem_to_reg), .alu_res(alu_res), .st_val(st_val), .dest(dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one instruction, let it clock into EXE/MEM, sample 1 ns after the edge.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                       input logic src, input logic [31:0] se, input logic s, input logic [4:0] d);
    exe_cmd_in  = cmd;
    val_rn_in   = rn;
    val_rm_in   = rm;
    alu_src_in  = src;
    sign_ext_in = se;
    s_in        = s;
    dest_in     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; mem_to_reg_in = 1'b0;
    b_in = 1'b0; s_in = 1'b0; alu_src_in = 1'b0; exe_cmd_in = 4'd0;
    next_pc_in = 32'd0; val_rn_in = 32'd0; val_rm_in = 32'd0; sign_ext_in = 32'd0;
    signed_imm_24_in = 24'd0; dest_in = 5'd0;
    #2;
    check("rst_alu_res", alu_res, 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_ctrl", 32'({wb_en, mem_r_en, mem_w_en, mem_to_reg}), 32'd0);
    check("rst_dest", 32'(dest), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1; mem_to_reg_in = 1'b1;
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 5'd3);
    check("add_res", alu_res, 32'd0);
    check("add_status", 32'(status), 32'b0110);
    check("add_dest", 32'(dest), 32'd3);
    check("add_st_val", st_val, 32'd1);
    check("add_ctrl", 32'({wb_en, mem_r_en, mem_w_en, mem_to_reg}), 32'b1011);

    wb_en_in = 1'b0; mem_w_en_in = 1'b0; mem_to_reg_in = 1'b0;
    issue(4'b0011, 32'd1, 32'd1, 1'b0, 32'd0, 1'b1, 5'd4);
    check("adc_res", alu_res, 32'd3);
    check("adc_status", 32'(status), 32'b0000);
    check("adc_ctrl", 32'({wb_en, mem_r_en, mem_w_en, mem_to_reg}), 32'b0000);

    issue(4'b0100, 32'h8000_0000, 32'd1, 1'b0, 32'd0, 1'b1, 5'd5);
    check("sub_res", alu_res, 32'h7FFF_FFFF);
    check("sub_status", 32'(status), 32'b0011);

    issue(4'b0110, 32'hF0, 32'h0F, 1'b0, 32'd0, 1'b1, 5'd6);
    check("and_res", alu_res, 32'd0);
    check("and_status", 32'(status), 32'b0111);

    issue(4'b0111, 32'hF0, 32'h0F, 1'b0, 32'd0, 1'b0, 5'd6);
    check("orr_res", alu_res, 32'hFF);
    check("orr_status_nos", 32'(status), 32'b0111);

    issue(4'b1000, 32'hFF, 32'h0F, 1'b0, 32'd0, 1'b1, 5'd6);
    check("eor_res", alu_res, 32'hF0);
    check("eor_status", 32'(status), 32'b0011);

    issue(4'b1001, 32'h1234, 32'd0, 1'b0, 32'd0, 1'b1, 5'd6);
    check("mvn_res", alu_res, 32'hFFFF_FFFF);
    check("mvn_status", 32'(status), 32'b1011);

    issue(4'b0000, 32'h1234, 32'h5678, 1'b0, 32'd0, 1'b1, 5'd6);
    check("nop_res", alu_res, 32'd0);
    check("nop_status", 32'(status), 32'b0111);

    issue(4'b0101, 32'd5, 32'd3, 1'b0, 32'd0, 1'b1, 5'd8);
    check("sbc_c1_res", alu_res, 32'd2);
    check("sbc_c1_status", 32'(status), 32'b0010);

    issue(4'b0010, 32'd1, 32'd1, 1'b0, 32'd0, 1'b1, 5'd8);
    check("add_clr_status", 32'(status), 32'b0000);
    issue(4'b0101, 32'd5, 32'd3, 1'b0, 32'd0, 1'b1, 5'd8);
    check("sbc_c0_res", alu_res, 32'd1);
    check("sbc_c0_status", 32'(status), 32'b0010);

    issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 5'd8);
    check("add_ovf_res", alu_res, 32'h8000_0000);
    check("add_ovf_status", 32'(status), 32'b1001);

    issue(4'b0001, 32'd0, 32'h55, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd7);
    check("mov_imm_res", alu_res, 32'hFFFF_FFFC);
    check("mov_imm_st_val", st_val, 32'h55);
    check("mov_imm_status", 32'(status), 32'b1001);

    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(4'b0010, 32'd1, 32'd1, 1'b0, 32'd0, 1'b1, 5'd9);
      check("frz_res", alu_res, 32'hFFFF_FFFC);
      check("frz_status", 32'(status), 32'b1001);
      check("frz_dest", 32'(dest), 32'd7);
    end
    freeze = 1'b0;
    issue(4'b0010, 32'd1, 32'd1, 1'b0, 32'd0, 1'b1, 5'd9);
    check("unfrz_res", alu_res, 32'd2);
    check("unfrz_status", 32'(status), 32'b0000);
    check("unfrz_dest", 32'(dest), 32'd9);

    s_in = 1'b0;
    b_in = 1'b1; next_pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE;
    #1;
    check("br_taken", 32'(branch_taken), 32'd1);
    check("br_addr_back", branch_addr, 32'h0000_00F8);
    next_pc_in = 32'h1000; signed_imm_24_in = 24'h000010; freeze = 1'b1;
    #1;
    check("br_taken_frz", 32'(branch_taken), 32'd1);
    check("br_addr_fwd", branch_addr, 32'h0000_1040);
    b_in = 1'b0; freeze = 1'b0;
    #1;
    check("br_not_taken", 32'(branch_taken), 32'd0);

    wb_en_in = 1'b1;
    issue(4'b0010, 32'd10, 32'd20, 1'b0, 32'd0, 1'b1, 5'd12);
    check("pre_rst_res", alu_res, 32'd30);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_res", alu_res, 32'd0);
    check("midrst_status", 32'(status), 32'd0);
    check("midrst_st_val", st_val, 32'd0);
    check("midrst_ctrl", 32'({wb_en, mem_r_en, mem_w_en, mem_to_reg}), 32'd0);
    check("midrst_dest", 32'(dest), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_res", alu_res, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
